// File: rtl/parallel_to_serial_if.sv
// Word handshake and serial-side status for the parallel-to-serial transmitter.
interface parallel_to_serial_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] parallel;
  logic             ready;
  logic             serial;
  logic             busy;
  logic             last;

  modport master (output valid, parallel, input ready, serial, busy, last);
  modport slave  (input valid, parallel, output ready, serial, busy, last);
endinterface

// File: rtl/parallel_to_serial.sv
// Serialises a WIDTH-bit word MSB first, one bit per enabled clock, with
// back-to-back reload on the final bit so a held valid streams with no gap.
module parallel_to_serial #(
  parameter int WIDTH = 8
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  parallel_to_serial_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             rdy;
  logic             accept;

  // Final-bit decode and handshake; in SHIFT a new word is only taken when
  // the LSB actually leaves on this edge, so no bit is ever dropped or doubled.
  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
  assign rdy      = (state == IDLE) || (last_bit && Enable);
  assign accept   = bus.valid && rdy;

  // State register; Reset abandons any frame in flight.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: leave SHIFT only after the LSB is shifted out with no reload.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (Enable && last_bit && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register and bit counter; Enable low freezes both mid-frame.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (accept) begin
      sreg <= bus.parallel;
      cnt  <= '0;
    end else if (state == SHIFT && Enable) begin
      if (last_bit) begin
        sreg <= '0;
        cnt  <= '0;
      end else begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        cnt  <= cnt + CW'(1);
      end
    end
  end

  // Outputs decoded from registered state only (ready excepted).
  always_comb begin
    bus.ready  = rdy;
    bus.busy   = (state == SHIFT);
    bus.last   = last_bit;
    bus.serial = (state == SHIFT) ? sreg[WIDTH-1] : 1'b0;
  end
endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: table-driven frames, hand-written corner
// sequences, and a negedge scoreboard with a receiver model for loopback.
module tb_parallel_to_serial;
  localparam int W = 8;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Enable = 1'b1;

  parallel_to_serial_if #(.WIDTH(W)) bus();

  parallel_to_serial #(.WIDTH(W)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Enable),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected bits/last per presented cycle, plus accepted words
  // for the receiver check.
  typedef struct { logic b; logic l; } bit_t;
  bit_t           bq[$];
  logic [W-1:0]   wq[$];
  logic [W-1:0]   rx = '0;
  logic [W-1:0]   rx_exp;
  bit             rx_pend = 0;

  always @(negedge Clock) begin
    if (Reset) begin
      bq.delete();
      wq.delete();
      rx_pend = 0;
    end else begin
      if (rx_pend) begin
        chk("rx_word", rx, rx_exp);
        rx_pend = 0;
      end
      chk("mon_busy", bus.busy, bq.size() != 0);
      if (bq.size() != 0) begin
        chk("mon_serial", bus.serial, bq[0].b);
        chk("mon_last", bus.last, bq[0].l);
      end else begin
        chk("mon_idle_serial", bus.serial, 0);
        chk("mon_idle_last", bus.last, 0);
      end
      if (Enable) begin
        rx = {rx[W-2:0], bus.serial};
        if (bus.last && bq.size() != 0) begin
          if (wq.size() != 0) begin
            rx_exp = wq.pop_front();
            rx_pend = 1;
          end
        end
        if (bq.size() != 0) void'(bq.pop_front());
      end
      if (bus.valid && bus.ready) begin
        logic [W-1:0] w;
        w = bus.parallel;
        wq.push_back(w);
        for (int k = 0; k < W; k++) bq.push_back('{b: w[W-1-k], l: (k == W-1)});
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // One frame with an optional Enable-low stall while bit stall_at is shown.
  task automatic send_frame(input logic [W-1:0] word, input int stall_at, input int stall_len,
                            output logic [W-1:0] cap, output int cycles);
    int k;
    int stalls;
    bus.valid = 1'b1;
    bus.parallel = word;
    Enable = 1'b1;
    #1;
    chk("send_ready", bus.ready, 1);
    step();
    bus.valid = 1'b0;
    bus.parallel = 8'h00;
    cap = '0;
    cycles = 0;
    k = 0;
    stalls = 0;
    while (bus.busy && cycles < 60) begin
      if (k == stall_at && stalls < stall_len) begin
        Enable = 1'b0;
        stalls++;
      end else begin
        Enable = 1'b1;
        if (k < W) cap[W-1-k] = bus.serial;
        k++;
      end
      cycles++;
      step();
    end
    Enable = 1'b1;
  endtask

  typedef struct {
    logic [W-1:0] word;
    int           stall_at;
    int           stall_len;
    logic [W-1:0] exp_bits;
    int           exp_cycles;
  } vec_t;

  initial begin
    vec_t         tbl[5];
    logic [W-1:0] cap;
    logic [15:0]  cap16;
    int           cyc;
    int           n;
    int           g;

    tbl[0] = '{8'hA5, -1, 0, 8'hA5, 8};
    tbl[1] = '{8'hC3,  2, 3, 8'hC3, 11};
    tbl[2] = '{8'h3C,  0, 2, 8'h3C, 10};
    tbl[3] = '{8'h01,  7, 4, 8'h01, 12};
    tbl[4] = '{8'hFF,  3, 1, 8'hFF, 9};

    // Reset with a word offered: nothing is accepted.
    bus.valid = 1'b1;
    bus.parallel = 8'hFF;
    Reset = 1'b1;
    step();
    step();
    step();
    chk("rst_serial", bus.serial, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_last", bus.last, 0);
    Reset = 1'b0;
    bus.valid = 1'b0;
    #1;
    chk("rst_ready", bus.ready, 1);
    step();
    chk("rst_no_accept", bus.busy, 0);

    // Table frames.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].word, tbl[i].stall_at, tbl[i].stall_len, cap, cyc);
      chk($sformatf("tbl%0d_bits", i), cap, tbl[i].exp_bits);
      chk($sformatf("tbl%0d_cycles", i), cyc, tbl[i].exp_cycles);
      step();
    end

    // Back-to-back: valid held, reload on the final bit, no gap.
    bus.valid = 1'b1;
    bus.parallel = 8'hA5;
    Enable = 1'b1;
    step();
    bus.parallel = 8'h3C;
    cap16 = '0;
    for (int c = 1; c <= 17; c++) begin
      if (c == 9) bus.valid = 1'b0;
      #1;
      if (c <= 16) begin
        chk($sformatf("b2b_ready_c%0d", c), bus.ready, (c == 8 || c == 16));
        chk($sformatf("b2b_busy_c%0d", c), bus.busy, 1);
        cap16[16-c] = bus.serial;
      end else begin
        chk("b2b_end_busy", bus.busy, 0);
      end
      step();
    end
    chk("b2b_bits", cap16, 16'hA53C);

    // Reset mid-frame at bit 4 of 0xF0, then a clean 0x81.
    bus.valid = 1'b1;
    bus.parallel = 8'hF0;
    step();
    bus.valid = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    chk("mid_busy_before", bus.busy, 1);
    Reset = 1'b1;
    step();
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_serial", bus.serial, 0);
    chk("mid_rst_last", bus.last, 0);
    Reset = 1'b0;
    step();
    send_frame(8'h81, -1, 0, cap, cyc);
    chk("mid_after_bits", cap, 8'h81);
    chk("mid_after_cycles", cyc, 8);
    step();

    // Loopback: random words, valid held, random Enable gaps.
    n = 0;
    g = 0;
    bus.valid = 1'b1;
    bus.parallel = W'($urandom);
    while (n < 20 && g < 2000) begin
      bit acc;
      Enable = ($urandom_range(0, 3) != 0);
      #1;
      acc = bus.ready;
      if (acc) n++;
      step();
      if (acc) bus.parallel = W'($urandom);
      g++;
    end
    bus.valid = 1'b0;
    Enable = 1'b1;
    g = 0;
    while (bus.busy && g < 100) begin
      step();
      g++;
    end
    step();
    step();
    chk("loop_accepts", n, 20);
    chk("loop_done", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
